// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req at or after ptr, searching upward with wrap.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0] sum_s;

  // Walk offsets from farthest to nearest so the nearest candidate wins last.
  always_comb begin
    found = 1'b0;
    idx   = {IDX_W{1'b0}};
    sum_s = {(IDX_W+1){1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      sum_s = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum_s >= (IDX_W+1)'(N)) begin
        sum_s = sum_s - (IDX_W+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      if (req[sum_s[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = sum_s[IDX_W-1:0];
      end else begin
        found = found;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  localparam int ID_W     = $clog2(NUM_REQ),
  localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_found_s;
  logic [ID_W-1:0]  pick_idx_s;
  logic             in_burst_s;
  logic             transfer_s;
  logic             release_s;
  logic [CNT_W-1:0] beat_inc_s;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Transfer/release qualification and the owner-steered write port.
  always_comb begin
    in_burst_s = (state_q == ST_BURST);
    transfer_s = in_burst_s && req_valid[owner_q] && !fifo_full;
    beat_inc_s = beat_cnt_q + CNT_W'(1);
    release_s  = transfer_s && (req_last[owner_q] || (beat_inc_s == CNT_W'(MAX_BURST)));
    req_ready  = {NUM_REQ{1'b0}};
    if (in_burst_s) begin
      req_ready[owner_q] = !fifo_full;
      fifo_din           = req_data[int'(owner_q)*DATA_W +: DATA_W];
      grant_id           = owner_q;
    end else begin
      fifo_din           = {DATA_W{1'b0}};
      grant_id           = {ID_W{1'b0}};
    end
    fifo_wr = transfer_s;
    busy    = in_burst_s;
  end

  // Next-state logic for the grant FSM and its bookkeeping registers.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          owner_d    = pick_idx_s;
          beat_cnt_d = {CNT_W{1'b0}};
          state_d    = ST_BURST;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (transfer_s) begin
          beat_cnt_d = beat_inc_s;
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
        // beat_cnt is left at its final value after release; IDLE clears it on the next grant.
        if (release_s) begin
          rr_ptr_d = (owner_q == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : owner_q + ID_W'(1);
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_BURST;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; an asserted reset abandons any burst in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= {ID_W{1'b0}};
      rr_ptr_q   <= {ID_W{1'b0}};
      beat_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 producers, 8-bit data, MAX_BURST 8).
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic [1:0]  grant_id;
  logic        busy;

  int checks;
  int failures;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (8),
    .MAX_BURST (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0000_0000;
    req_last  = 4'b0000;
    fifo_full = 1'b0;

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr", {31'd0, fifo_wr}, 32'd0);
    chk("rst_gid", {30'd0, grant_id}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_ptr", {30'd0, dut.rr_ptr_q}, 32'd0);
    rst = 1'b1;

    // 1: single short burst from producer 0
    tick();
    req_valid = 4'b0001;
    req_data[7:0] = 8'hA1;
    #1;
    chk("t1_idle_wr", {31'd0, fifo_wr}, 32'd0);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    #1;
    chk("t1_b0_wr", {31'd0, fifo_wr}, 32'd1);
    chk("t1_b0_din", {24'd0, fifo_din}, 32'hA1);
    chk("t1_b0_ready", {28'd0, req_ready}, 32'h1);
    chk("t1_b0_busy", {31'd0, busy}, 32'd1);
    tick();
    req_data[7:0] = 8'hA2;
    #1;
    chk("t1_b1_wr", {31'd0, fifo_wr}, 32'd1);
    chk("t1_b1_din", {24'd0, fifo_din}, 32'hA2);
    tick();
    req_data[7:0] = 8'hA3;
    req_last = 4'b0001;
    #1;
    chk("t1_b2_wr", {31'd0, fifo_wr}, 32'd1);
    chk("t1_b2_din", {24'd0, fifo_din}, 32'hA3);
    tick();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    #1;
    chk("t1_end_busy", {31'd0, busy}, 32'd0);
    chk("t1_end_wr", {31'd0, fifo_wr}, 32'd0);
    chk("t1_end_ptr", {30'd0, dut.rr_ptr_q}, 32'd1);
    chk("t1_end_cnt", {28'd0, dut.beat_cnt_q}, 32'd3);

    // 2: fairness with single-beat bursts from every producer, starting at rr_ptr 1
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = 32'hD3D2_D1D0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t2_idle_wr", {31'd0, fifo_wr}, 32'd0);
      tick();
      #1;
      chk("t2_gid", {30'd0, grant_id}, 32'((1 + k) % 4));
      chk("t2_wr", {31'd0, fifo_wr}, 32'd1);
      chk("t2_din", {24'd0, fifo_din}, 32'(8'hD0 + 8'((1 + k) % 4)));
      tick();
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    #1;
    chk("t2_end_ptr", {30'd0, dut.rr_ptr_q}, 32'd3);

    // 3: MAX_BURST release, producer 1 streams while producer 2 waits
    req_valid = 4'b0110;
    req_last  = 4'b0100;
    req_data[23:16] = 8'h2F;
    req_data[15:8]  = 8'h10;
    #1;
    chk("t3_idle_wr", {31'd0, fifo_wr}, 32'd0);
    tick();
    for (int b = 0; b < 8; b++) begin
      req_data[15:8] = 8'(8'h10 + b);
      #1;
      chk("t3_gid", {30'd0, grant_id}, 32'd1);
      chk("t3_din", {24'd0, fifo_din}, 32'(8'h10 + b));
      chk("t3_wr", {31'd0, fifo_wr}, 32'd1);
      tick();
    end
    req_data[15:8] = 8'h18;
    #1;
    chk("t3_rel_busy", {31'd0, busy}, 32'd0);
    chk("t3_rel_ptr", {30'd0, dut.rr_ptr_q}, 32'd2);
    chk("t3_rel_cnt", {28'd0, dut.beat_cnt_q}, 32'd8);
    tick();
    #1;
    chk("t3_p2_gid", {30'd0, grant_id}, 32'd2);
    chk("t3_p2_din", {24'd0, fifo_din}, 32'h2F);
    chk("t3_p2_wr", {31'd0, fifo_wr}, 32'd1);
    tick();
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    #1;
    chk("t3_gap_busy", {31'd0, busy}, 32'd0);
    tick();
    #1;
    chk("t3_rest_gid", {30'd0, grant_id}, 32'd1);
    chk("t3_rest0_din", {24'd0, fifo_din}, 32'h18);
    chk("t3_rest0_wr", {31'd0, fifo_wr}, 32'd1);
    tick();
    req_data[15:8] = 8'h19;
    req_last = 4'b0010;
    #1;
    chk("t3_rest1_din", {24'd0, fifo_din}, 32'h19);
    tick();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    #1;
    chk("t3_end_ptr", {30'd0, dut.rr_ptr_q}, 32'd2);

    // 4: full backpressure during cycles 2..4 of a 5-beat burst from producer 2
    req_valid = 4'b0100;
    req_data[23:16] = 8'h40;
    tick();
    #1;
    chk("t4_c1_wr", {31'd0, fifo_wr}, 32'd1);
    chk("t4_c1_din", {24'd0, fifo_din}, 32'h40);
    tick();
    req_data[23:16] = 8'h41;
    fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_full_wr", {31'd0, fifo_wr}, 32'd0);
      chk("t4_full_ready", {28'd0, req_ready}, 32'd0);
      chk("t4_full_cnt", {28'd0, dut.beat_cnt_q}, 32'd1);
      tick();
    end
    fifo_full = 1'b0;
    for (int b = 1; b < 5; b++) begin
      req_data[23:16] = 8'(8'h40 + b);
      req_last = (b == 4) ? 4'b0100 : 4'b0000;
      #1;
      chk("t4_wr", {31'd0, fifo_wr}, 32'd1);
      chk("t4_din", {24'd0, fifo_din}, 32'(8'h40 + b));
      chk("t4_ready", {28'd0, req_ready}, 32'h4);
      tick();
    end
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    #1;
    chk("t4_end_busy", {31'd0, busy}, 32'd0);
    chk("t4_end_cnt", {28'd0, dut.beat_cnt_q}, 32'd5);
    chk("t4_end_ptr", {30'd0, dut.rr_ptr_q}, 32'd3);

    // 5: owner 0 stalls for 4 cycles while producer 3 requests
    req_valid = 4'b0001;
    req_data[7:0] = 8'h50;
    tick();
    #1;
    chk("t5_b0_din", {24'd0, fifo_din}, 32'h50);
    tick();
    req_valid = 4'b1000;
    req_data[31:24] = 8'h77;
    req_last = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("t5_stall_wr", {31'd0, fifo_wr}, 32'd0);
      chk("t5_stall_gid", {30'd0, grant_id}, 32'd0);
      chk("t5_stall_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    req_valid = 4'b1001;
    req_data[7:0] = 8'h51;
    req_last = 4'b1001;
    #1;
    chk("t5_resume_wr", {31'd0, fifo_wr}, 32'd1);
    chk("t5_resume_din", {24'd0, fifo_din}, 32'h51);
    chk("t5_resume_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("t5_rel_busy", {31'd0, busy}, 32'd0);
    chk("t5_rel_ptr", {30'd0, dut.rr_ptr_q}, 32'd1);
    tick();
    #1;
    chk("t5_p3_gid", {30'd0, grant_id}, 32'd3);
    chk("t5_p3_din", {24'd0, fifo_din}, 32'h77);
    tick();
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    #1;
    chk("t5_end_ptr", {30'd0, dut.rr_ptr_q}, 32'd0);

    // 6: asynchronous reset in the middle of a burst from producer 2
    req_valid = 4'b0100;
    req_data[23:16] = 8'h60;
    tick();
    #1;
    chk("t6_pre_gid", {30'd0, grant_id}, 32'd2);
    chk("t6_pre_busy", {31'd0, busy}, 32'd1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_wr", {31'd0, fifo_wr}, 32'd0);
    chk("t6_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_gid", {30'd0, grant_id}, 32'd0);
    chk("t6_rst_din", {24'd0, fifo_din}, 32'd0);
    req_valid = 4'b1010;
    req_last  = 4'b1010;
    req_data[15:8] = 8'h81;
    req_data[31:24] = 8'h83;
    tick();
    rst = 1'b1;
    #1;
    chk("t6_post_ptr", {30'd0, dut.rr_ptr_q}, 32'd0);
    chk("t6_post_busy", {31'd0, busy}, 32'd0);
    tick();
    #1;
    chk("t6_first_gid", {30'd0, grant_id}, 32'd1);
    chk("t6_first_din", {24'd0, fifo_din}, 32'h81);
    chk("t6_first_wr", {31'd0, fifo_wr}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
